start_delay_gen: RTL and testbench

Pseudo-random start-stimulus generator for the reaction-timer datapath. It sits directly upstream of the counter control FSM and drives that FSM's active-high `start` line. After the player arms a round, it waits a pseudo-random number of millisecond ticks, then raises `start` (LED on) and holds it until the round is cleared. A press during the wait is flagged as a false start and aborts the round without ever raising `start`.

---
 rtl/start_delay_gen.sv | 120 ++++++++++++
 tb/tb_start_delay_gen.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/start_delay_gen.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// start_delay_gen
//
// Pseudo-random start-stimulus generator for the reaction-timer datapath.
// After a rising edge on arm it waits (MIN_TICKS + lfsr) delay ticks of
// TICK_DIV clocks each, then raises start and holds it until clr. A clr
// during the wait is a false start: the round aborts without start ever
// rising and the sticky false_start flag is set.
//
// Handshake: arm is a level request, and only its rising edge starts a
// round. clr is a single-cycle or level acknowledge. It ends the round in
// WAIT or FIRE and is ignored in IDLE. start stays high from the firing edge
// until the edge that samples clr in FIRE.
//
// Ports
//   clk          in   system clock, rising edge
//   ar           in   asynchronous reset, active-high
//   arm          in   round request (level, synchronous)
//   clr          in   round clear / player press (synchronous)
//   start        out  stimulus to counter FSM (registered)
//   busy         out  high whenever the FSM is not IDLE
//   false_start  out  sticky: clr arrived during WAIT
//   lfsr_q       out  current 8-bit LFSR value (debug)
// ---------------------------------------------------------------------------
module start_delay_gen #(
  parameter int TICK_DIV  = 10000,
  parameter int MIN_TICKS = 250
) (
  input  logic       clk,
  input  logic       ar,
  input  logic       arm,
  input  logic       clr,
  output logic       start,
  output logic       busy,
  output logic       false_start,
  output logic [7:0] lfsr_q
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_FIRE = 2'd2
  } state_t;

  // Prescaler wrap value held in 16 bits, so TICK_DIV = 65536 still fits.
  localparam logic [15:0] PS_LAST    = 16'(TICK_DIV - 1);
  localparam logic [8:0]  MIN_TICKS9 = 9'(MIN_TICKS);

  state_t      state_q;
  logic        arm_q;
  logic [8:0]  dly_q;
  logic [15:0] ps_q;

  logic [7:0]  lfsr_d;
  logic [8:0]  dly_d;
  logic        arm_rise;

  // Fibonacci taps 8,6,5,4: maximal length, so a nonzero seed never
  // reaches zero.
  assign lfsr_d   = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
  // The delay uses the value before this edge's shift. The 9-bit sum cannot
  // overflow.
  assign dly_d    = MIN_TICKS9 + {1'b0, lfsr_q};
  assign arm_rise = arm & ~arm_q;
  assign busy     = (state_q != S_IDLE);

  always_ff @(posedge clk or posedge ar) begin
    if (ar) begin
      state_q     <= S_IDLE;
      arm_q       <= 1'b0;
      dly_q       <= '0;
      ps_q        <= '0;
      lfsr_q      <= 8'h01;
      start       <= 1'b0;
      false_start <= 1'b0;
    end else begin
      lfsr_q <= lfsr_d;
      arm_q  <= arm;
      case (state_q)
        S_IDLE: begin
          // clr is deliberately ignored here, even on the accept edge.
          if (arm_rise) begin
            dly_q       <= dly_d;
            ps_q        <= '0;
            false_start <= 1'b0;
            state_q     <= S_WAIT;
          end
        end
        S_WAIT: begin
          // A press beats a coincident final tick, so start never pulses.
          if (clr) begin
            false_start <= 1'b1;
            state_q     <= S_IDLE;
          end else if (ps_q == PS_LAST) begin
            ps_q  <= '0;
            dly_q <= dly_q - 9'd1;
            if (dly_q == 9'd1) begin
              start   <= 1'b1;
              state_q <= S_FIRE;
            end
          end else begin
            ps_q <= ps_q + 16'd1;
          end
        end
        S_FIRE: begin
          if (clr) begin
            start   <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        default: begin
          start   <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_start_delay_gen.sv
`timescale 1ns/1ps
module tb_start_delay_gen;

  localparam int TD = 4;
  localparam int MT = 2;

  // ---------------- clock / reset / DUT ----------------
  logic       clk = 1'b0;
  logic       ar;
  logic       arm;
  logic       clr;
  logic       start;
  logic       busy;
  logic       false_start;
  logic [7:0] lfsr_q;

  always #5 clk = ~clk;

  start_delay_gen #(
    .TICK_DIV  (TD),
    .MIN_TICKS (MT)
  ) dut (
    .clk         (clk),
    .ar          (ar),
    .arm         (arm),
    .clr         (clr),
    .start       (start),
    .busy        (busy),
    .false_start (false_start),
    .lfsr_q      (lfsr_q)
  );

  // ---------------- scoreboard state ----------------
  int         n_compared   = 0;
  int         n_mismatched = 0;
  logic [7:0] exp_lfsr;

  function automatic logic [7:0] lfsr_next(input logic [7:0] q);
    return {q[6:0], q[7] ^ q[5] ^ q[4] ^ q[3]};
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_compared++;
    if (obs !== exp) begin
      n_mismatched++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // One active edge. The LFSR model advances with the DUT, and the task
  // returns 1 ns after the edge so that outputs are settled.
  task automatic step();
    @(posedge clk);
    if (!ar) exp_lfsr = lfsr_next(exp_lfsr);
    #1;
  endtask

  // Called right after the accept edge. Runs d*TD edges. start must stay low
  // and busy high until the last edge, and start must rise exactly on it.
  task automatic wait_fire(input int d, input string tag);
    logic early;
    logic dropped;
    early   = 1'b0;
    dropped = 1'b0;
    for (int i = 1; i <= d * TD; i++) begin
      step();
      if (i < d * TD && start) early = 1'b1;
      if (!busy) dropped = 1'b1;
      if (i == d * TD - 1) check_eq({tag, "_start_pre"}, start, 1'b0);
    end
    check_eq({tag, "_start_early"}, early, 1'b0);
    check_eq({tag, "_busy_dropped"}, dropped, 1'b0);
    check_eq({tag, "_start_fire"}, start, 1'b1);
  endtask

  // Drop arm for one edge, then raise it at the next edge. Returns the
  // expected delay D from the LFSR value seen on the accept edge.
  task automatic rearm(input logic with_clr, output int d);
    arm = 1'b0;
    step();
    arm = 1'b1;
    clr = with_clr;
    d   = MT + int'(exp_lfsr);
    step();
    clr = 1'b0;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #1ms;
    $display("FAIL watchdog: time limit reached, summary not printed");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int         d;
    int         hits;
    logic [2:0] seen;
    logic       st_seen;

    ar       = 1'b1;
    arm      = 1'b0;
    clr      = 1'b0;
    exp_lfsr = 8'h01;

    // Reset and idle
    repeat (3) step();
    check_eq("rst_start", start, 1'b0);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_fs", false_start, 1'b0);
    check_eq("rst_lfsr", lfsr_q, 8'h01);
    ar   = 1'b0;
    seen = '0;
    hits = 0;
    for (int i = 1; i <= 255; i++) begin
      step();
      check_eq("idle_lfsr", lfsr_q, exp_lfsr);
      seen |= {start, busy, false_start};
      if (i < 255 && lfsr_q == 8'h01) hits++;
    end
    check_eq("idle_period_back", lfsr_q, 8'h01);
    check_eq("idle_early_repeat", hits, 0);
    check_eq("idle_outputs", seen, 3'b000);

    // Basic latency. arm is already high when reset releases, so the first
    // edge accepts a round with lfsr=01, giving D=3 and 12 edges.
    ar       = 1'b1;
    arm      = 1'b1;
    exp_lfsr = 8'h01;
    step();
    step();
    check_eq("rst2_lfsr", lfsr_q, 8'h01);
    check_eq("rst2_busy", busy, 1'b0);
    ar = 1'b0;
    step();
    check_eq("basic_busy_accept", busy, 1'b1);
    check_eq("basic_start_accept", start, 1'b0);
    wait_fire(3, "basic");
    clr = 1'b1;
    step();
    clr = 1'b0;
    check_eq("basic_clr_start", start, 1'b0);
    check_eq("basic_clr_busy", busy, 1'b0);

    // Arm held high through the round and the clr: no second round.
    seen = '0;
    repeat (20) begin
      step();
      seen |= {start, busy, false_start};
    end
    check_eq("held_no_round", seen, 3'b000);

    // Re-arm. D comes from the LFSR value on the accept edge.
    rearm(1'b0, d);
    check_eq("rearm_busy", busy, 1'b1);
    wait_fire(d, "rearm");
    clr = 1'b1;
    step();
    clr = 1'b0;
    check_eq("rearm_clr_start", start, 1'b0);
    check_eq("rearm_clr_busy", busy, 1'b0);
    check_eq("rearm_clr_fs", false_start, 1'b0);

    // False start: clr sampled 5 edges after the accept edge.
    rearm(1'b0, d);
    check_eq("fs_busy_accept", busy, 1'b1);
    repeat (4) step();
    clr = 1'b1;
    step();
    clr = 1'b0;
    check_eq("fs_busy", busy, 1'b0);
    check_eq("fs_flag", false_start, 1'b1);
    check_eq("fs_start", start, 1'b0);
    st_seen = 1'b0;
    repeat (3) begin
      step();
      st_seen |= start;
    end
    check_eq("fs_sticky", false_start, 1'b1);
    check_eq("fs_no_start", st_seen, 1'b0);

    // Collision. The accept edge also carries clr, which must be ignored in
    // IDLE. Later, clr lands on the final-tick edge.
    rearm(1'b1, d);
    check_eq("col_accept_busy", busy, 1'b1);
    check_eq("col_accept_fs_clear", false_start, 1'b0);
    st_seen = 1'b0;
    for (int i = 1; i < d * TD; i++) begin
      step();
      st_seen |= start;
    end
    clr = 1'b1;
    step();
    clr = 1'b0;
    st_seen |= start;
    check_eq("col_busy", busy, 1'b0);
    check_eq("col_fs", false_start, 1'b1);
    step();
    st_seen |= start;
    check_eq("col_no_start", st_seen, 1'b0);

    // Reset mid-FIRE, asserted between edges.
    rearm(1'b0, d);
    wait_fire(d, "final");
    #2;
    ar = 1'b1;
    #1;
    check_eq("async_start", start, 1'b0);
    check_eq("async_busy", busy, 1'b0);
    check_eq("async_lfsr", lfsr_q, 8'h01);
    exp_lfsr = 8'h01;
    arm      = 1'b0;
    #2;
    ar = 1'b0;
    step();
    check_eq("post_rst_lfsr", lfsr_q, exp_lfsr);
    check_eq("post_rst_busy", busy, 1'b0);

    // ---------------- report ----------------
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
